data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressable, big-endian data memory behind a fixed-latency IDLE/WAIT/DONE
// access FSM, with a combinational stall request and a one-cycle done strobe.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  mem_rw,
  input  logic                  mem_size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  align_fault
);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  rw_reg, size_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           read_data_reg;
  logic                  align_fault_reg;
  logic                  accept, access, fault;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [1:0]            lane_sel;
  logic [7:0]            lane_rd [4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_busy   = 1'b0;
    mem_done   = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state_reg)
      IDLE: begin
        mem_busy = mem_enable;
        if (mem_enable) begin
          accept     = 1'b1;
          state_next = WAIT;
          cnt_next   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        mem_busy = 1'b1;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          access     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        mem_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fault    = size_reg && (addr_reg[1:0] != 2'b00);
  assign word_idx = addr_reg[ADDR_WIDTH-1:2];
  assign lane_sel = addr_reg[1:0];

  // Four byte lanes; lane 0 is the lowest address of a word and holds bits [31:24].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic       we;
      logic [7:0] wd;

      assign we = access && rw_reg && !fault && (size_reg || (lane_sel == 2'(gi)));
      assign wd = size_reg ? wdata_reg[31-8*gi -: 8] : wdata_reg[7:0];

      always_ff @(posedge clk) begin
        if (we) begin
          mem[word_idx] <= wd;
        end
      end

      assign lane_rd[gi] = mem[word_idx];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_reg          <= 1'b0;
      size_reg        <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      read_data_reg   <= '0;
      align_fault_reg <= 1'b0;
    end else begin
      align_fault_reg <= access && fault;
      if (accept) begin
        rw_reg    <= mem_rw;
        size_reg  <= mem_size;
        addr_reg  <= addr;
        wdata_reg <= write_data;
      end
      if (access && !rw_reg && !fault) begin
        read_data_reg <= size_reg ? {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]}
                                  : {24'h0, lane_rd[lane_sel]};
      end
    end
  end

  assign read_data   = read_data_reg;
  assign align_fault = align_fault_reg;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (latency 1 and 3) driven from a vector
// table with a scoreboard, plus hand sequences for stall, held enable and reset.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en [2];
  logic        rw [2];
  logic        sz [2];
  logic [7:0]  ad [2];
  logic [31:0] wd [2];
  logic [31:0] rdata [2];
  logic        busy [2];
  logic        done [2];
  logic        fault [2];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  typedef struct {
    int          d;
    logic        w;
    logic        s;
    logic [7:0]  a;
    logic [31:0] data;
    logic [31:0] rd;
    logic        f;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        f;
    int          lat;
  } exp_t;

  vec_t vecs [$];
  exp_t sb [$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .mem_enable(en[0]), .mem_rw(rw[0]), .mem_size(sz[0]),
    .addr(ad[0]), .write_data(wd[0]), .read_data(rdata[0]), .mem_busy(busy[0]),
    .mem_done(done[0]), .align_fault(fault[0])
  );

  data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset(reset), .mem_enable(en[1]), .mem_rw(rw[1]), .mem_size(sz[1]),
    .addr(ad[1]), .write_data(wd[1]), .read_data(rdata[1]), .mem_busy(busy[1]),
    .mem_done(done[1]), .align_fault(fault[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One access from an IDLE negedge through the DONE cycle and back to IDLE.
  task automatic access(input int d, input logic w, input logic s, input logic [7:0] a,
                        input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_f);
    exp_t e;
    int   k;
    @(negedge clk);
    en[d] = 1'b1; rw[d] = w; sz[d] = s; ad[d] = a; wd[d] = data;
    sb.push_back('{rd: exp_rd, f: exp_f, lat: (d == 0) ? 1 : 3});
    #1 check("busy_request", 32'(busy[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    en[d] = 1'b0; rw[d] = ~w; sz[d] = ~s; ad[d] = ~a; wd[d] = ~data;
    #1 check("busy_wait", 32'(busy[d]), 32'd1);
    k = 0;
    while (!done[d] && k < 40) begin
      @(negedge clk);
      #1 k++;
    end
    e = sb.pop_front();
    check("latency", 32'(k), 32'(e.lat));
    check("read_data", rdata[d], e.rd);
    check("align_fault", 32'(fault[d]), 32'(e.f));
    check("busy_done", 32'(busy[d]), 32'd0);
    $display("txn dut%0d %s %s addr=%h wdata=%h -> read_data=%h align_fault=%0d latency=%0d",
             d, w ? "WR" : "RD", s ? "word" : "byte", a, data, rdata[d], fault[d], k);
    @(negedge clk);
    #1 check("done_low_after", 32'(done[d]), 32'd0);
    check("fault_low_after", 32'(fault[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int holds;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; rw[i] = 1'b0; sz[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end

    // Latency-1 instance
    vecs.push_back('{0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b0, 8'h10, 32'h0,        32'h000000DE, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b0, 8'h13, 32'h0,        32'h000000EF, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 8'h11, 32'hAAAAAA55, 32'h000000EF, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 8'h10, 32'h0,        32'hDE55BEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b1, 8'h12, 32'h01020304, 32'hDE55BEEF, 1'b1});
    vecs.push_back('{0, 1'b0, 1'b1, 8'h10, 32'h0,        32'hDE55BEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 8'h11, 32'h0,        32'hDE55BEEF, 1'b1});
    vecs.push_back('{0, 1'b0, 1'b0, 8'h12, 32'h0,        32'h000000BE, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b1, 8'hFC, 32'hCAFEF00D, 32'h000000BE, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 8'hFE, 32'h00000077, 32'h000000BE, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 8'hFC, 32'h0,        32'hCAFE770D, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b0, 8'hFF, 32'h0,        32'h0000000D, 1'b0});
    // Latency-3 instance
    vecs.push_back('{1, 1'b1, 1'b1, 8'h20, 32'h11223344, 32'h00000000, 1'b0});
    vecs.push_back('{1, 1'b0, 1'b1, 8'h20, 32'h0,        32'h11223344, 1'b0});
    vecs.push_back('{1, 1'b1, 1'b1, 8'h24, 32'hA0B0C0D0, 32'h11223344, 1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 8'h27, 32'h00000099, 32'h11223344, 1'b0});
    vecs.push_back('{1, 1'b0, 1'b1, 8'h24, 32'h0,        32'hA0B0C099, 1'b0});
    vecs.push_back('{1, 1'b0, 1'b0, 8'h26, 32'h0,        32'h000000C0, 1'b0});

    // Reset state; busy still follows mem_enable while held in reset
    #1 reset = 1'b0;
    en[0] = 1'b1;
    #12;
    for (int i = 0; i < 2; i++) begin
      check("reset_read_data", rdata[i], 32'h0);
      check("reset_done", 32'(done[i]), 32'd0);
      check("reset_fault", 32'(fault[i]), 32'd0);
    end
    check("reset_busy_en", 32'(busy[0]), 32'd1);
    check("reset_busy_idle", 32'(busy[1]), 32'd0);
    en[0] = 1'b0;
    #1 check("reset_busy_drop", 32'(busy[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      access(vecs[i].d, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].data, vecs[i].rd, vecs[i].f);
    end

    // Stall profile with enable held through DONE: exactly one access
    @(negedge clk);
    en[1] = 1'b1; rw[1] = 1'b0; sz[1] = 1'b1; ad[1] = 8'h20;
    #1 check("held_busy_request", 32'(busy[1]), 32'd1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("held_busy", 32'(busy[1]), (i < 3) ? 32'd1 : 32'd0);
      check("held_done", 32'(done[1]), (i == 3) ? 32'd1 : 32'd0);
    end
    check("held_read_data", rdata[1], 32'h11223344);
    $display("txn dut1 RD word addr=20 held-enable -> read_data=%h", rdata[1]);
    @(negedge clk);
    #1 check("held_idle_busy_en", 32'(busy[1]), 32'd1);
    en[1] = 1'b0;
    #1 check("held_no_restart", 32'(busy[1]), 32'd0);
    holds = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done[1]) holds++;
    end
    check("held_single_access", 32'(holds), 32'd0);

    // Reset asserted mid-WAIT aborts the write
    @(negedge clk);
    en[1] = 1'b1; rw[1] = 1'b1; sz[1] = 1'b1; ad[1] = 8'h20; wd[1] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    en[1] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("abort_read_data", rdata[1], 32'h0);
    check("abort_done", 32'(done[1]), 32'd0);
    check("abort_fault", 32'(fault[1]), 32'd0);
    check("abort_busy", 32'(busy[1]), 32'd0);
    check("abort_other_read_data", rdata[0], 32'h0);
    $display("txn dut1 WR word addr=20 wdata=12345678 aborted by reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Memory survives reset on both instances
    access(1, 1'b0, 1'b1, 8'h20, 32'h0, 32'h11223344, 1'b0);
    access(0, 1'b0, 1'b1, 8'h10, 32'h0, 32'hDE55BEEF, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
